hazard_ctrl_unit: RTL
=====================

Name: hazard_ctrl_unit

Overview:
Parametrised successor to the pipeline's hazard unit. Central stall/flush controller for the 5-stage pipeline. Detects load-use hazards on both rs and rt and inserts a configurable number of bubbles. Also handles branch/jump flushes, instruction/data memory wait freezes and saturating performance counters, all from a registered state machine.

Parameters:
LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..4).
CNT_W, 32, width of stall_cnt and flush_cnt.

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous reset, active-high
ifid_rs  input  regbits_t  rs field of instruction in IF/ID
ifid_rt  input  regbits_t  rt field of instruction in IF/ID
ifid_uses_rt  input  1  IF/ID instruction reads rt (R-type, BEQ/BNE, SW)
idex_rt  input  regbits_t  destination rt of instruction in ID/EX
idex_dren  input  1  ID/EX instruction is a load
idex_jump  input  1  ID/EX holds J/JAL/JR
idex_branch  input  1  ID/EX holds BEQ/BNE
idex_beq  input  1  1=BEQ, 0=BNE
alu_zero  input  1  ALU zero flag for ID/EX instruction
ihit  input  1  instruction fetch complete this cycle
exmem_dmem_req  input  1  EX/MEM issuing dren or dwen
dhit  input  1  data access complete this cycle
pc_en  output  1  PC load enable
ifid_en  output  1  IF/ID latch enable
ifid_flush  output  1  IF/ID clear to NOP
idex_en  output  1  ID/EX latch enable
idex_flush  output  1  ID/EX clear to NOP
exmem_en  output  1  EX/MEM latch enable
memwb_en  output  1  MEM/WB latch enable
stall_cnt  output  CNT_W  bubbles/freeze cycles since reset, saturating
flush_cnt  output  CNT_W  control flushes since reset, saturating
hz_state  output  hz_state_t  current FSM state (debug)

Behaviour:
- One clock CLK; reset is synchronous and active-high on RST. While RST is high at an edge: state<=RUN, bubble counter<=0, stall_cnt<=0, flush_cnt<=0. While RST is high, all *_en=0 and all *_flush=0. Reset mid-stall abandons the stall with no residual bubbles.
- Hazard terms (combinational):
  - lu_hit = idex_dren & (idex_rt!=0) & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)).
  - ctl_taken = idex_jump | (idex_branch & (idex_beq ? alu_zero : ~alu_zero)).
  - mem_wait = exmem_dmem_req & ~dhit.
- Priority, evaluated each cycle: mem_wait > ctl_taken > lu_hit > ~ihit > normal.
- States: RUN, LU_STALL, MEM_WAIT.
- RUN:
  - Normal: all enables 1, flushes 0.
  - mem_wait: all five enables 0; next state MEM_WAIT; stall_cnt+1.
  - ctl_taken: pc_en=1 (target loads); ifid_flush=1; idex_flush=1; flush_cnt+1; stay RUN. A load-use hit in the same cycle is ignored because its consumer is killed.
  - lu_hit: pc_en=0, ifid_en=0, idex_flush=1; stall_cnt+1.
    - LU_STALL_CYCLES==1: stay RUN.
    - Otherwise: load counter with LU_STALL_CYCLES-1; next state LU_STALL.
  - ~ihit: pc_en=0, ifid_flush=1, other stages advance; stall_cnt+1.
- LU_STALL:
  - Same outputs as the lu_hit bubble; counter decrements; stall_cnt+1.
  - Return to RUN on the cycle the counter reaches 1.
  - If mem_wait occurs: freeze (all enables 0), counter holds, state unchanged. Remaining bubbles resume after dhit.
- MEM_WAIT: all enables 0; stall_cnt+1 per cycle. When dhit is seen, outputs return to RUN behaviour that same cycle and the next state is RUN.
- Latency: all hazard responses are combinational in the detection cycle. State and counters update on the following edge.
- Counters saturate at 2^CNT_W-1; no wrap.
- idex_rt==0 never stalls. A single stall cycle increments stall_cnt by exactly 1, even if both rs and rt match.

Decomposition:
- cpu_types_pkg gains hz_state_t (enum RUN, LU_STALL, MEM_WAIT) and the constant LU_STALL_MAX=4.
- New interface hazard_ctrl_if with modports hcu and tb.
- One sub-module, sat_counter (parametrised width, synchronous clear, inc, saturate). Instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- LW $5 in ID/EX, ADD using rs=$5 in IF/ID, LU_STALL_CYCLES=2 -> 2 cycles of pc_en=0/idex_flush=1, then resume; stall_cnt=2.
- LW to $0 followed by a consumer of $0 -> no stall; SW reading rt=$7 after LW $7 -> 1 bubble; ifid_uses_rt=0 with rt match -> no stall.
- BNE with alu_zero=0 in ID/EX, plus a simultaneous load-use match -> ifid_flush=idex_flush=1, pc_en=1, no bubble; flush_cnt=1.
- exmem_dmem_req=1, dhit low 3 cycles, during LU_STALL (LU_STALL_CYCLES=3) -> all enables 0 for 3 cycles, remaining bubbles resume afterwards; total stall_cnt=6.
- ihit=0 for 2 cycles in RUN -> pc_en=0, ifid_flush=1, idex_en=1; stall_cnt=2.
- RST pulsed mid-LU_STALL -> next cycle RUN, counters 0; CNT_W=4 with 20 stalls -> stall_cnt holds at 15.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types for the 5-stage CPU.
//
// Contents:
//   regbits_t     - register-file index (5 bits)
//   hz_state_t    - hazard controller FSM state (RUN, LU_STALL, MEM_WAIT)
//   LU_STALL_MAX  - largest legal load-use bubble count
//   branch_taken  - resolves BEQ/BNE against the ALU zero flag
package cpu_types_pkg;

  localparam int REG_W        = 5;
  localparam int LU_STALL_MAX = 4;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  // BEQ is taken on zero, BNE on non-zero.
  function automatic logic branch_taken(input logic is_beq, input logic zero);
    return is_beq ? zero : ~zero;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of every signal crossing the hazard controller boundary.
//
// Modports:
//   hcu - the controller's view (pipeline status in, enables/flushes/counters out)
//   tb  - the driving side's view (mirror of hcu)
interface hazard_ctrl_if
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic             rst;
  regbits_t         ifid_rs;
  regbits_t         ifid_rt;
  logic             ifid_uses_rt;
  regbits_t         idex_rt;
  logic             idex_dren;
  logic             idex_jump;
  logic             idex_branch;
  logic             idex_beq;
  logic             alu_zero;
  logic             ihit;
  logic             exmem_dmem_req;
  logic             dhit;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  hz_state_t        hz_state;

  modport hcu (
    input  rst, ifid_rs, ifid_rt, ifid_uses_rt, idex_rt, idex_dren,
           idex_jump, idex_branch, idex_beq, alu_zero, ihit,
           exmem_dmem_req, dhit,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, stall_cnt, flush_cnt, hz_state
  );

  modport tb (
    output rst, ifid_rs, ifid_rt, ifid_uses_rt, idex_rt, idex_dren,
           idex_jump, idex_branch, idex_beq, alu_zero, ihit,
           exmem_dmem_req, dhit,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           memwb_en, stall_cnt, flush_cnt, hz_state
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//
// Ports:
//   clk   - rising-edge clock
//   clear - synchronous clear, dominates inc
//   inc   - add one this cycle unless already at all-ones
//   count - current value, sticks at 2^W-1
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Counting stops at all-ones so long runs never wrap back to small values.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Central stall/flush controller for the 5-stage pipeline.
//
// Handles, in priority order: data-memory wait freezes, taken branch/jump
// flushes, load-use bubbles (LU_STALL_CYCLES per hazard) and fetch misses.
// All responses are combinational in the cycle the condition is seen; the
// FSM state and the performance counters update on the following edge.
//
// Ports:
//   CLK, RST                  - clock, synchronous active-high reset
//   ifid_rs/rt, ifid_uses_rt  - source operands of the IF/ID instruction
//   idex_rt, idex_dren        - destination and load flag of ID/EX
//   idex_jump/branch/beq      - control-flow kind of ID/EX
//   alu_zero                  - ALU zero flag for the ID/EX instruction
//   ihit                      - instruction fetch done this cycle
//   exmem_dmem_req, dhit      - data access outstanding / done
//   *_en, *_flush             - per-stage latch enables and NOP clears
//   stall_cnt, flush_cnt      - saturating stall and flush counters
//   hz_state                  - current FSM state for debug
module hazard_ctrl_unit
  import cpu_types_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  input  logic             ifid_uses_rt,
  input  regbits_t         idex_rt,
  input  logic             idex_dren,
  input  logic             idex_jump,
  input  logic             idex_branch,
  input  logic             idex_beq,
  input  logic             alu_zero,
  input  logic             ihit,
  input  logic             exmem_dmem_req,
  input  logic             dhit,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output hz_state_t        hz_state
);

  hz_state_t  state, state_nxt;
  logic [2:0] bub_cnt, bub_nxt;
  logic       lu_hit, ctl_taken, mem_wait;
  logic       run_mode;
  logic       stall_inc, flush_inc;

  // A load into $0 never creates a dependency; rt only matters when the
  // consumer actually reads it.
  assign lu_hit    = idex_dren && (idex_rt != '0) &&
                     ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
  assign ctl_taken = idex_jump || (idex_branch && branch_taken(idex_beq, alu_zero));
  assign mem_wait  = exmem_dmem_req && !dhit;

  // State register. bub_cnt holds the bubbles still owed, counting the one
  // being issued in the current LU_STALL cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      bub_cnt <= '0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_nxt;
    end
  end

  // Next-state and output decode. LU_STALL and MEM_WAIT fall back to the
  // RUN decision (run_mode) once they are no longer holding the pipe, so the
  // RUN priority chain only exists once. Reset forces every enable and
  // flush low last so it overrides whatever the chain chose.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    state_nxt  = state;
    bub_nxt    = bub_cnt;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    run_mode   = 1'b0;

    unique case (state)
      RUN: begin
        run_mode = 1'b1;
      end
      LU_STALL: begin
        stall_inc = 1'b1;
        if (mem_wait) begin
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end else begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          if (bub_cnt <= 3'd1) begin
            state_nxt = RUN;
            bub_nxt   = '0;
          end else begin
            bub_nxt = bub_cnt - 3'd1;
          end
        end
      end
      MEM_WAIT: begin
        if (!dhit) begin
          pc_en     = 1'b0;
          ifid_en   = 1'b0;
          idex_en   = 1'b0;
          exmem_en  = 1'b0;
          memwb_en  = 1'b0;
          stall_inc = 1'b1;
        end else begin
          run_mode = 1'b1;
        end
      end
      default: begin
        run_mode = 1'b1;
      end
    endcase

    if (run_mode) begin
      state_nxt = RUN;
      bub_nxt   = '0;
      if (mem_wait) begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        idex_en   = 1'b0;
        exmem_en  = 1'b0;
        memwb_en  = 1'b0;
        stall_inc = 1'b1;
        state_nxt = MEM_WAIT;
      end else if (ctl_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (lu_hit) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        stall_inc  = 1'b1;
        if (LU_STALL_CYCLES > 1) begin
          state_nxt = LU_STALL;
          bub_nxt   = 3'(LU_STALL_CYCLES - 1);
        end
      end else if (!ihit) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        stall_inc  = 1'b1;
      end
    end

    if (RST) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_en    = 1'b0;
      idex_flush = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
    end
  end

  assign hz_state = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .clear (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .clear (RST),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
